// File: rtl/servant_gpio_seq.sv
// Autonomous GPIO pattern sequencer: Wishbone config slave plus a master port that replays a pattern table.
// Define GPIO_SEQ_IRQ_EN to add the sticky o_irq output, mirrored in STATUS bit2.

module servant_gpio_seq #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] GPIO_ADR = 32'h0
) (
  input  logic        i_wb_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic [31:0] o_gpio_adr,
  output logic [31:0] o_gpio_dat,
  output logic        o_gpio_we,
  output logic        o_gpio_cyc
`ifdef GPIO_SEQ_IRQ_EN
  ,
  output logic        o_irq
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT, DONE} state_t;

  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  state_t      state, state_next;
  logic        en, oneshot;
  logic [31:0] period;
  logic [3:0]  len;
  logic [31:0] pattern [8];
  logic [2:0]  index, index_next;
  logic [31:0] count, count_next;
  logic        done, done_next;
  logic        irq;
  logic        busy;
  logic        last_step;
  logic [3:0]  sel;
  logic        cfg_wr, ctrl_wr, start, stop;
  logic [3:0]  len_eff;
  logic [31:0] period_eff;
  logic [31:0] rd_data;

  wire unused_adr = ^{i_wb_adr[31:6], i_wb_adr[1:0]};

  assign sel        = i_wb_adr[5:2];
  assign cfg_wr     = i_wb_cyc & i_wb_we & ~o_wb_ack;
  assign ctrl_wr    = cfg_wr && (sel == 4'd0);
  assign start      = ctrl_wr && i_wb_dat[0] && (state == IDLE || state == DONE);
  assign stop       = ctrl_wr && !i_wb_dat[0];
  assign len_eff    = (len == 4'd0) ? 4'd1 : (len > DEPTH_L) ? DEPTH_L : len;
  assign period_eff = (period == 32'd0) ? 32'd1 : period;
  assign busy       = (state == WRITE) || (state == WAIT);
  assign o_gpio_adr = GPIO_ADR;

  always_comb begin
    state_next = state;
    index_next = index;
    count_next = count;
    done_next  = done;
    last_step  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = WRITE;
          index_next = 3'd0;
          done_next  = 1'b0;
        end
      end
      WRITE: begin
        last_step = ({1'b0, index} >= (len_eff - 4'd1));
        if (last_step && oneshot) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          index_next = last_step ? 3'd0 : index + 3'd1;
          if (period_eff == 32'd1) begin
            state_next = WRITE;
          end else begin
            state_next = WAIT;
            count_next = period_eff - 32'd1;
          end
        end
      end
      WAIT: begin
        if (count <= 32'd1) state_next = WRITE;
        else                count_next = count - 32'd1;
      end
      default: state_next = IDLE;
    endcase
    // Clearing EN wins over everything; a WRITE already on the bus still finishes this cycle.
    if (stop) begin
      state_next = IDLE;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      index      <= 3'd0;
      count      <= 32'd0;
      done       <= 1'b0;
      o_gpio_cyc <= 1'b0;
      o_gpio_we  <= 1'b0;
      o_gpio_dat <= 32'd0;
    end else begin
      state      <= state_next;
      index      <= index_next;
      count      <= count_next;
      done       <= done_next;
      o_gpio_cyc <= (state_next == WRITE);
      o_gpio_we  <= (state_next == WRITE);
      o_gpio_dat <= (state_next == WRITE) ? pattern[index_next] : 32'd0;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (sel)
      4'd0:    rd_data = {30'd0, oneshot, en};
      4'd1:    rd_data = period;
      4'd2:    rd_data = {28'd0, len};
      4'd3:    rd_data = {25'd0, index, 1'b0, irq, done, busy};
      default: if (sel[3]) rd_data = pattern[sel[2:0]];
    endcase
  end

  // Entries at or above DEPTH are never written, so they stay zero and read back as 0.
  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en       <= 1'b0;
      oneshot  <= 1'b0;
      period   <= 32'd1;
      len      <= DEPTH_L;
      o_wb_ack <= 1'b0;
      o_wb_rdt <= 32'd0;
      for (int i = 0; i < 8; i++) pattern[i] <= 32'd0;
    end else begin
      o_wb_ack <= i_wb_cyc & ~o_wb_ack;
      if (i_wb_cyc & ~o_wb_ack) o_wb_rdt <= rd_data;
      if (cfg_wr) begin
        case (sel)
          4'd0:    {oneshot, en} <= i_wb_dat[1:0];
          4'd1:    period <= i_wb_dat;
          4'd2:    len <= i_wb_dat[3:0];
          default: ;
        endcase
        if (sel[3] && (int'(sel[2:0]) < DEPTH)) pattern[sel[2:0]] <= i_wb_dat;
      end
    end
  end

`ifdef GPIO_SEQ_IRQ_EN
  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n)                        irq <= 1'b0;
    else if (last_step)                  irq <= 1'b1;
    else if (cfg_wr && (sel == 4'd3))    irq <= 1'b0;
  end
  assign o_irq = irq;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_servant_gpio_seq.sv
// Self-checking bench for servant_gpio_seq: time-based reference model, per-cycle compare, directed and random stimulus.
// Honours GPIO_SEQ_IRQ_EN when the design is built with it.

module tb_servant_gpio_seq;

  localparam int          DEPTH    = 8;
  localparam logic [31:0] GPIO_ADR = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wbAdr = 32'd0;
  logic [31:0] wbDat = 32'd0;
  logic        wbWe = 1'b0;
  logic        wbCyc = 1'b0;
  logic [31:0] wbRdt;
  logic        wbAck;
  logic [31:0] gpioAdr;
  logic [31:0] gpioDat;
  logic        gpioWe;
  logic        gpioCyc;
`ifdef GPIO_SEQ_IRQ_EN
  logic        irqOut;
`endif

  int checkCount = 0;
  int passCount  = 0;
  int tbCycle    = 0;

  int          pulseTime [$];
  logic [31:0] pulseData [$];

  servant_gpio_seq #(.DEPTH(DEPTH), .GPIO_ADR(GPIO_ADR)) dut (
    .i_wb_clk  (clk),
    .i_rst_n   (rst_n),
    .i_wb_adr  (wbAdr),
    .i_wb_dat  (wbDat),
    .i_wb_we   (wbWe),
    .i_wb_cyc  (wbCyc),
    .o_wb_rdt  (wbRdt),
    .o_wb_ack  (wbAck),
    .o_gpio_adr(gpioAdr),
    .o_gpio_dat(gpioDat),
    .o_gpio_we (gpioWe),
    .o_gpio_cyc(gpioCyc)
`ifdef GPIO_SEQ_IRQ_EN
    ,
    .o_irq     (irqOut)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) tbCycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Reference model: the sequencer is "running" with writes scheduled at absolute cycle numbers.
  logic        mEn, mOs, mRunning, mDone, mIrq, mAck, mCyc;
  logic [31:0] mPer, mRdt, mDat;
  logic [3:0]  mLen;
  logic [31:0] mPat [8];
  logic [31:0] oldPat [8];
  int          mIdx;
  longint      mN = 0;
  longint      mNxt;
  logic        tWr, tWasRunning, tIrqSet, tLast;
  logic [3:0]  tSel;

  function automatic int lenEff();
    int le = (mLen == 4'd0) ? 1 : int'(mLen);
    if (le > DEPTH) le = DEPTH;
    return le;
  endfunction

  function automatic longint perEff();
    return (mPer == 32'd0) ? 64'd1 : longint'(mPer);
  endfunction

  function automatic logic [31:0] modelRead(input logic [3:0] sel);
    logic [31:0] r = 32'd0;
    case (sel)
      4'd0: r = {30'd0, mOs, mEn};
      4'd1: r = mPer;
      4'd2: r = {28'd0, mLen};
      4'd3: begin
        r[0]   = mRunning;
        r[1]   = mDone;
`ifdef GPIO_SEQ_IRQ_EN
        r[2]   = mIrq;
`endif
        r[6:4] = mIdx[2:0];
      end
      default: if (sel >= 4'd8) r = mPat[sel - 4'd8];
    endcase
    return r;
  endfunction

  task automatic modelReset();
    mEn = 1'b0; mOs = 1'b0; mPer = 32'd1; mLen = 4'(DEPTH);
    for (int i = 0; i < 8; i++) mPat[i] = 32'd0;
    mRunning = 1'b0; mDone = 1'b0; mIrq = 1'b0; mIdx = 0; mNxt = 0;
    mAck = 1'b0; mRdt = 32'd0; mCyc = 1'b0; mDat = 32'd0;
  endtask

  initial modelReset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelReset();
    end else begin
      mN++;
      tWr = wbCyc & wbWe & ~mAck;
      tSel = wbAdr[5:2];
      oldPat = mPat;
      tWasRunning = mRunning;
      tIrqSet = 1'b0;
      if (wbCyc && !mAck) mRdt = modelRead(tSel);
      mAck = wbCyc & ~mAck;
      if (mCyc) begin
        tLast = (mIdx >= lenEff() - 1);
        if (tLast) tIrqSet = 1'b1;
        if (tLast && mOs) begin
          mRunning = 1'b0;
          mDone = 1'b1;
        end else begin
          mIdx = tLast ? 0 : mIdx + 1;
          mNxt = mN - 1 + perEff();
        end
      end
      if (tWr) begin
        case (tSel)
          4'd0: begin
            mEn = wbDat[0];
            mOs = wbDat[1];
            if (!wbDat[0]) begin
              mRunning = 1'b0;
              mDone = 1'b0;
            end else if (!tWasRunning) begin
              mRunning = 1'b1;
              mDone = 1'b0;
              mIdx = 0;
              mNxt = mN;
            end
          end
          4'd1: mPer = wbDat;
          4'd2: mLen = wbDat[3:0];
          default: if (tSel >= 4'd8 && int'(tSel - 4'd8) < DEPTH) mPat[tSel - 4'd8] = wbDat;
        endcase
      end
      if (tIrqSet) mIrq = 1'b1;
      else if (tWr && tSel == 4'd3) mIrq = 1'b0;
      mCyc = mRunning && (mNxt == mN);
      mDat = mCyc ? oldPat[mIdx] : 32'd0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("gpio_cyc_we", {30'd0, gpioCyc, gpioWe}, {30'd0, mCyc, mCyc});
      checkOutput("gpio_dat", gpioDat, mDat);
      checkOutput("gpio_adr", gpioAdr, GPIO_ADR);
      checkOutput("wb_ack", {31'd0, wbAck}, {31'd0, mAck});
      if (mAck) checkOutput("wb_rdt", wbRdt, mRdt);
`ifdef GPIO_SEQ_IRQ_EN
      checkOutput("irq", {31'd0, irqOut}, {31'd0, mIrq});
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_n && gpioCyc) begin
      pulseTime.push_back(tbCycle);
      pulseData.push_back(gpioDat);
    end
  end

  function automatic logic [31:0] dataAt(input int k);
    return (k < pulseData.size()) ? pulseData[k] : 32'hDEAD_BEEF;
  endfunction

  function automatic int timeAt(input int k);
    return (k < pulseTime.size()) ? pulseTime[k] : -1000;
  endfunction

  task automatic clearPulses();
    pulseTime.delete();
    pulseData.delete();
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wbXfer(input logic [31:0] adr, input logic we, input logic [31:0] dat, output logic [31:0] rd);
    @(posedge clk);
    #1;
    wbCyc = 1'b1; wbWe = we; wbAdr = adr; wbDat = dat;
    @(posedge clk);
    #1;
    rd = wbRdt;
    wbCyc = 1'b0; wbWe = 1'b0;
  endtask

  task automatic wbWrite(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    wbXfer(adr, 1'b1, dat, dummy);
  endtask

  task automatic wbRead(input logic [31:0] adr, output logic [31:0] rd);
    wbXfer(adr, 1'b0, 32'd0, rd);
  endtask

  task automatic waitPulses(input int need, input int maxCycles, input string name);
    for (int i = 0; i < maxCycles && pulseData.size() < need; i++) @(posedge clk);
    #1;
    checkOutput(name, {31'd0, pulseData.size() >= need}, 32'd1);
  endtask

  // Random register traffic; everything it provokes is checked by the per-cycle compare.
  task automatic applyStimulus(input int iters);
    logic [31:0] rd;
    logic [31:0] adr;
    logic [3:0]  sel;
    int          op;
    for (int it = 0; it < iters; it++) begin
      op  = $urandom_range(0, 9);
      adr = $urandom;
      case (op)
        0, 1: begin sel = 4'd0; adr[5:2] = sel; wbWrite(adr, 32'($urandom_range(0, 3))); end
        2:    begin sel = 4'd1; adr[5:2] = sel; wbWrite(adr, 32'($urandom_range(0, 5))); end
        3:    begin sel = 4'd2; adr[5:2] = sel; wbWrite(adr, 32'($urandom_range(0, 15))); end
        4:    begin sel = 4'(8 + $urandom_range(0, 7)); adr[5:2] = sel; wbWrite(adr, $urandom); end
        5:    begin sel = 4'd3; adr[5:2] = sel; wbWrite(adr, $urandom); end
        6:    begin sel = 4'(4 + $urandom_range(0, 3)); adr[5:2] = sel; wbWrite(adr, $urandom); end
        7, 8: begin sel = 4'($urandom_range(0, 15)); adr[5:2] = sel; wbRead(adr, rd); end
        default: waitCycles($urandom_range(1, 8));
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          edgeCycle;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_gpio_cyc", {31'd0, gpioCyc}, 32'd0);
    checkOutput("reset_gpio_adr", gpioAdr, GPIO_ADR);
    rst_n = 1'b1;

    wbRead(32'h00, rd); checkOutput("reset_ctrl", rd, 32'd0);
    wbRead(32'h04, rd); checkOutput("reset_period", rd, 32'd1);
    wbRead(32'h08, rd); checkOutput("reset_len", rd, 32'd8);
    wbRead(32'h0C, rd); checkOutput("reset_status", rd, 32'd0);
    for (int i = 0; i < 8; i++) begin
      wbRead(32'(32 + 4 * i), rd);
      checkOutput("reset_pattern", rd, 32'd0);
    end

    $display("[TB] one-shot run");
    wbWrite(32'h20, 32'hA);
    wbWrite(32'h24, 32'hB);
    wbWrite(32'h28, 32'hC);
    wbWrite(32'h08, 32'd3);
    wbWrite(32'h04, 32'd4);
    clearPulses();
    wbWrite(32'h00, 32'd3);
    edgeCycle = tbCycle;
    waitCycles(20);
    checkOutput("oneshot_count", 32'(pulseData.size()), 32'd3);
    checkOutput("oneshot_d0", dataAt(0), 32'hA);
    checkOutput("oneshot_d1", dataAt(1), 32'hB);
    checkOutput("oneshot_d2", dataAt(2), 32'hC);
    checkOutput("oneshot_t0", 32'(timeAt(0) - edgeCycle), 32'd0);
    checkOutput("oneshot_t1", 32'(timeAt(1) - timeAt(0)), 32'd4);
    checkOutput("oneshot_t2", 32'(timeAt(2) - timeAt(1)), 32'd4);
    wbRead(32'h0C, rd);
`ifdef GPIO_SEQ_IRQ_EN
    checkOutput("oneshot_status", rd, 32'h26);
    checkOutput("irq_set", {31'd0, irqOut}, 32'd1);
    wbWrite(32'h0C, 32'd0);
    checkOutput("irq_clear", {31'd0, irqOut}, 32'd0);
`else
    checkOutput("oneshot_status", rd, 32'h22);
`endif

    $display("[TB] continuous run");
    wbWrite(32'h20, 32'h11);
    wbWrite(32'h24, 32'h22);
    wbWrite(32'h08, 32'd2);
    wbWrite(32'h04, 32'd1);
    clearPulses();
    wbWrite(32'h00, 32'd1);
    edgeCycle = tbCycle;
    waitCycles(6);
    checkOutput("cont_d0", dataAt(0), 32'h11);
    checkOutput("cont_d1", dataAt(1), 32'h22);
    checkOutput("cont_d2", dataAt(2), 32'h11);
    checkOutput("cont_d3", dataAt(3), 32'h22);
    checkOutput("cont_t3", 32'(timeAt(3) - edgeCycle), 32'd3);
    wbWrite(32'h00, 32'd0);
    clearPulses();
    waitCycles(5);
    checkOutput("cont_stop", 32'(pulseData.size()), 32'd0);

    $display("[TB] boundary LEN=0 PERIOD=0");
    wbWrite(32'h08, 32'd0);
    wbWrite(32'h04, 32'd0);
    clearPulses();
    wbWrite(32'h00, 32'd1);
    waitCycles(4);
    checkOutput("len0_d0", dataAt(0), 32'h11);
    checkOutput("len0_d1", dataAt(1), 32'h11);
    checkOutput("len0_d2", dataAt(2), 32'h11);
    checkOutput("len0_t2", 32'(timeAt(2) - timeAt(0)), 32'd2);
    wbWrite(32'h00, 32'd0);

    $display("[TB] boundary LEN=15");
    for (int i = 0; i < 8; i++) wbWrite(32'(32 + 4 * i), 32'(256 + i));
    wbWrite(32'h08, 32'd15);
    wbWrite(32'h04, 32'd1);
    clearPulses();
    wbWrite(32'h00, 32'd1);
    waitCycles(10);
    for (int k = 0; k < 9; k++) checkOutput("len15_data", dataAt(k), 32'(256 + (k % 8)));
    wbWrite(32'h00, 32'd0);

    $display("[TB] live LEN change");
    wbWrite(32'h08, 32'd8);
    wbWrite(32'h04, 32'd3);
    clearPulses();
    wbWrite(32'h00, 32'd1);
    waitPulses(3, 20, "live_first3");
    wbWrite(32'h08, 32'd1);
    waitPulses(6, 40, "live_six");
    checkOutput("live_d3", dataAt(3), 32'h103);
    checkOutput("live_d4", dataAt(4), 32'h100);
    checkOutput("live_d5", dataAt(5), 32'h100);
    wbWrite(32'h00, 32'd0);

    $display("[TB] reset during WAIT");
    wbWrite(32'h08, 32'd2);
    wbWrite(32'h04, 32'd4);
    clearPulses();
    wbWrite(32'h00, 32'd1);
    waitPulses(1, 10, "rst_first");
    waitCycles(2);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_gpio_cyc", {31'd0, gpioCyc}, 32'd0);
    checkOutput("rst_gpio_dat", gpioDat, 32'd0);
    checkOutput("rst_wb_ack", {31'd0, wbAck}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wbRead(32'h0C, rd); checkOutput("post_rst_status", rd, 32'd0);
    wbRead(32'h00, rd); checkOutput("post_rst_ctrl", rd, 32'd0);
    wbRead(32'h04, rd); checkOutput("post_rst_period", rd, 32'd1);

    $display("[TB] reset during WRITE");
    wbWrite(32'h04, 32'd1);
    wbWrite(32'h00, 32'd1);
    waitCycles(2);
    checkOutput("run_gpio_cyc", {31'd0, gpioCyc}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_drop_cyc", {31'd0, gpioCyc}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] random traffic");
    applyStimulus(400);
    wbWrite(32'h00, 32'd0);
    waitCycles(4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/servant_gpio_seq.md
Name: servant_gpio_seq

Overview:
- Autonomous pattern sequencer for the servant GPIO output register.
- The CPU programs a small pattern table, a step period and a length through a Wishbone config slave.
- A master port then writes the pattern entries to the GPIO block one at a time, at a fixed cadence, in one-shot or continuous mode.
- No CPU involvement is needed per step; the block sits between the CPU data bus and the existing GPIO write port.

Parameters:
- DEPTH, 8, pattern table entries; legal 1..8.
- GPIO_ADR, 32'h0, address driven on o_gpio_adr (GPIO data register offset).

Ports:
- i_wb_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wb_adr  in  32  config address; only [5:2] decoded
- i_wb_dat  in  32  config write data
- i_wb_we  in  1  config write enable
- i_wb_cyc  in  1  config cycle
- o_wb_rdt  out  32  config read data (registered)
- o_wb_ack  out  1  config acknowledge
- o_gpio_adr  out  32  master address to GPIO, constant GPIO_ADR
- o_gpio_dat  out  32  master write data
- o_gpio_we  out  1  master write enable
- o_gpio_cyc  out  1  master cycle; the GPIO block needs no ack and accepts in one cycle

Behaviour:
- Clock and reset: one clock, i_wb_clk; reset i_rst_n is asynchronous, active-low.
- Reset values:
  - All outputs 0, except o_gpio_adr = GPIO_ADR.
  - CTRL = 0, PERIOD = 1, LEN = DEPTH, pattern entries = 0, index = 0, state IDLE.
- Config slave:
  - o_wb_ack <= i_wb_cyc & ~o_wb_ack, giving a one-cycle ack pulse.
  - Writes are committed on the edge where i_wb_cyc & i_wb_we & ~o_wb_ack.
  - o_wb_rdt is registered and valid with ack.
- Register map (adr[5:2]):
  - 0 CTRL (rw): bit0 EN, bit1 ONESHOT.
  - 1 PERIOD (rw): 32-bit cycles between writes; 0 is treated as 1.
  - 2 LEN (rw): 4-bit; 0 is treated as 1; values > DEPTH are clamped to DEPTH.
  - 3 STATUS (ro): bit0 busy (state WAIT/WRITE), bit1 done, bit2 irq (see option), bits[6:4] index.
  - 8..15 pattern[adr[4:2]] (rw); entries >= DEPTH read 0 and ignore writes.
  - Other addresses read 0 and ignore writes.
- FSM states: IDLE, WRITE, WAIT, DONE.
  - IDLE: when a CTRL write sets EN=1 (from any EN value): index <= 0, go to WRITE.
  - WRITE (exactly 1 cycle): o_gpio_cyc = o_gpio_we = 1, o_gpio_dat = pattern[index].
    - Last entry is reached when index >= LEN_eff-1.
    - Last entry and ONESHOT: go to DONE.
    - Last entry and not ONESHOT: index <= 0.
    - Not last entry: index++.
    - Then go to WAIT with counter = PERIOD_eff-1, or go straight to WRITE if PERIOD_eff = 1.
  - WAIT: counter decrements each cycle; at 0, go to WRITE.
  - DONE: outputs idle, done = 1; a new EN=1 write restarts from index 0.
- Master outputs are registered:
  - First o_gpio_cyc pulse occurs in the cycle after the enabling config write edge.
  - Successive pulses start exactly PERIOD_eff cycles apart; PERIOD_eff = 1 gives continuous cyc with a new value each cycle.
- EN cleared by a CTRL write: go to IDLE on that edge from any state.
  - A WRITE cycle in progress during that edge still completes.
  - No further GPIO writes occur.
  - done is cleared.
- Writes to PERIOD, LEN or pattern while running take effect at the next counter load, wrap check or read of that entry; they do not abort a step.
- Reset mid-sequence: immediate return to reset values; o_gpio_cyc drops asynchronously.

Optional Feature:
- Macro GPIO_SEQ_IRQ_EN.
- When defined:
  - The block adds output o_irq (1 bit, reset 0).
  - o_irq is set on the edge where WRITE completes the last entry, in both one-shot and continuous modes.
  - o_irq is sticky and is cleared by any write to STATUS (address 3).
  - A set and a clear on the same edge resolve to set.
  - STATUS bit2 mirrors o_irq.
- When undefined: no o_irq port, and STATUS bit2 reads 0.

Test Plan:
- Reset then read all registers -> CTRL=0, PERIOD=1, LEN=DEPTH, pattern=0; o_gpio_cyc never asserted.
- One-shot run: pattern[0..2] = 0xA,0xB,0xC; LEN=3; PERIOD=4; CTRL=3 -> three single-cycle o_gpio_cyc pulses with data A,B,C; rising edges 4 cycles apart; first pulse in the cycle after the CTRL write; then STATUS done=1, busy=0.
- Continuous run: LEN=2, PERIOD=1, CTRL=1 -> o_gpio_cyc held high with data alternating p0,p1,p0,...; write CTRL=0 -> no pulses after the following cycle.
- Boundary values: LEN=0 with PERIOD=0 -> behaves as LEN=1, PERIOD=1. LEN=15 -> clamped to DEPTH; index wraps at DEPTH-1.
- Live reconfiguration: LEN reduced to 1 while index=3 in continuous mode -> next step wraps to index 0.
- Abort and IRQ: assert i_rst_n low during WAIT -> outputs 0 immediately; after release, state IDLE. With GPIO_SEQ_IRQ_EN: o_irq rises at the final WRITE and clears on a STATUS write.
